// File: rtl/wbr_sd2_chain.sv
// Wrapper boundary register segment of NUM_CELLS dual-stage shared-I/O cells.
// The serial path runs wsi->s0[0]->s1[0]->...->s1[N-1]->wso, and an optional update stage drives cfo.
module wbr_sd2_chain #(
  parameter int                   NUM_CELLS  = 4,
  parameter int                   UPD_STAGE  = 1,
  parameter logic [NUM_CELLS-1:0] SAFE_VALUE = '0,
  parameter logic [NUM_CELLS-1:0] UPD_RST    = '0
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 wsi,
  output logic                 wso,
  input  logic                 shift,
  input  logic                 capture,
  input  logic                 transfer,
  input  logic                 update,
  input  logic                 io_face,
  input  logic                 mode,
  input  logic                 safe,
  input  logic [NUM_CELLS-1:0] cfi,
  output logic [NUM_CELLS-1:0] cfo
);

  logic [NUM_CELLS-1:0] s0;
  logic [NUM_CELLS-1:0] s1;
  logic [NUM_CELLS-1:0] u;
  logic [NUM_CELLS-1:0] si;
  logic [NUM_CELLS-1:0] cap_val;

  // The serial input of each cell is the s1 stage of the cell before it.
  always_comb begin
    si[0] = wsi;
    for (int i = 1; i < NUM_CELLS; i++) begin
      si[i] = s1[i-1];
    end
  end

  // With the outward face selected, capture samples the value on cfo before the edge.
  // The value only reaches a flop, so there is no combinational loop.
  assign cap_val = io_face ? cfo : cfi;

  always_ff @(posedge clk) begin
    if (arst) begin
      s0 <= '0;
      s1 <= '0;
    end else if (shift) begin
      s0 <= si;
      s1 <= s0;
    end else if (capture) begin
      s1 <= cap_val;
    end else if (transfer) begin
      s1 <= s0;
    end
  end

  // The update stage runs alongside the shift stage and takes the s1 value from before the edge.
  always_ff @(posedge clk) begin
    if (arst) begin
      u <= UPD_RST;
    end else if ((UPD_STAGE != 0) && update) begin
      u <= s1;
    end
  end

  assign wso = s1[NUM_CELLS-1];

  always_comb begin
    cfo = cfi;
    if (mode) begin
      if (safe) begin
        cfo = SAFE_VALUE;
      end else if (UPD_STAGE != 0) begin
        cfo = u;
      end else begin
        cfo = s1;
      end
    end
  end

endmodule

// File: tb/tb_wbr_sd2_chain.sv
// Scoreboard bench for wbr_sd2_chain: a 4-cell build with an update stage, and a 1-cell build without one.
// A flat serial-vector model predicts wso and cfo for every cycle.
module tb_wbr_sd2_chain;

  localparam logic [3:0] SAFE_A = 4'b1001;
  localparam logic [3:0] URST_A = 4'b0101;
  localparam logic [0:0] SAFE_B = 1'b1;
  localparam logic [0:0] URST_B = 1'b1;

  typedef struct packed {
    logic       arst;
    logic       shift;
    logic       capture;
    logic       transfer;
    logic       update;
    logic       io_face;
    logic       mode;
    logic       safe;
    logic       wsi;
    logic [3:0] cfi;
  } stim_t;

  // ch holds the serial chain in shift order: ch[2i] is s0 of cell i and ch[2i+1] is s1.
  typedef struct packed {
    logic [7:0] ch;
    logic [3:0] u;
  } mdl_t;

  typedef struct packed {
    logic       wso_a;
    logic [3:0] cfo_a;
    logic       wso_b;
    logic       cfo_b;
  } exp_t;

  logic clk = 1'b0;
  logic arst, wsi, shift, capture, transfer, update, io_face, mode, safe;
  logic [3:0] cfi;
  logic wso_a, wso_b;
  logic [3:0] cfo_a;
  logic [0:0] cfo_b;

  exp_t exp_q[$];
  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  wbr_sd2_chain #(.NUM_CELLS(4), .UPD_STAGE(1), .SAFE_VALUE(SAFE_A), .UPD_RST(URST_A)) dut_a (
    .clk(clk), .arst(arst), .wsi(wsi), .wso(wso_a), .shift(shift), .capture(capture),
    .transfer(transfer), .update(update), .io_face(io_face), .mode(mode), .safe(safe),
    .cfi(cfi), .cfo(cfo_a)
  );

  wbr_sd2_chain #(.NUM_CELLS(1), .UPD_STAGE(0), .SAFE_VALUE(SAFE_B), .UPD_RST(URST_B)) dut_b (
    .clk(clk), .arst(arst), .wsi(wsi), .wso(wso_b), .shift(shift), .capture(capture),
    .transfer(transfer), .update(update), .io_face(io_face), .mode(mode), .safe(safe),
    .cfi(cfi[0:0]), .cfo(cfo_b)
  );

  function automatic logic [3:0] model_cfo(mdl_t m, int n, bit upd, logic [3:0] sv, stim_t s);
    logic [3:0] s1v;
    logic [3:0] mask;
    s1v  = '0;
    mask = 4'((1 << n) - 1);
    for (int i = 0; i < n; i++) s1v[i] = m.ch[2*i+1];
    if (!s.mode) return s.cfi & mask;
    if (s.safe)  return sv & mask;
    return upd ? (m.u & mask) : s1v;
  endfunction

  function automatic mdl_t model_step(mdl_t m, int n, bit upd, logic [3:0] urst, logic [3:0] sv, stim_t s);
    mdl_t       nx;
    logic [3:0] face;
    logic [7:0] cmask;
    nx    = m;
    cmask = 8'((1 << (2*n)) - 1);
    if (s.arst) begin
      nx.ch = '0;
      nx.u  = urst;
      return nx;
    end
    face = s.io_face ? model_cfo(m, n, upd, sv, s) : s.cfi;
    if (s.shift) begin
      nx.ch = {m.ch[6:0], s.wsi} & cmask;
    end else if (s.capture) begin
      for (int i = 0; i < n; i++) nx.ch[2*i+1] = face[i];
    end else if (s.transfer) begin
      for (int i = 0; i < n; i++) nx.ch[2*i+1] = m.ch[2*i];
    end
    if (s.update && upd) begin
      for (int i = 0; i < n; i++) nx.u[i] = m.ch[2*i+1];
    end
    return nx;
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue the response expected after the next rising edge.
  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    logic [3:0] cb;
    @(negedge clk);
    arst = s.arst; shift = s.shift; capture = s.capture; transfer = s.transfer;
    update = s.update; io_face = s.io_face; mode = s.mode; safe = s.safe;
    wsi = s.wsi; cfi = s.cfi;
    ma = model_step(ma, 4, 1'b1, URST_A, SAFE_A, s);
    mb = model_step(mb, 1, 1'b0, {3'b0, URST_B}, {3'b0, SAFE_B}, s);
    cb = model_cfo(mb, 1, 1'b0, {3'b0, SAFE_B}, s);
    e.wso_a = ma.ch[7];
    e.cfo_a = model_cfo(ma, 4, 1'b1, SAFE_A, s);
    e.wso_b = mb.ch[1];
    e.cfo_b = cb[0];
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  // The monitor compares one queued entry shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("wso_a", {3'b0, wso_a}, {3'b0, e.wso_a});
        check_output("cfo_a", cfo_a, e.cfo_a);
        check_output("wso_b", {3'b0, wso_b}, {3'b0, e.wso_b});
        check_output("cfo_b", {3'b0, cfo_b}, {3'b0, e.cfo_b});
      end
    end
  end

  task automatic shift_bits(input logic [7:0] bits, input int cnt, input stim_t base);
    stim_t s;
    s = base;
    s.shift = 1'b1;
    for (int k = cnt - 1; k >= 0; k--) begin
      s.wsi = bits[k];
      apply_stimulus(s);
    end
  endtask

  initial begin
    stim_t s;
    stim_t idle;
    ma = '0;
    mb = '0;
    arst = 1'b0; wsi = 1'b0; shift = 1'b0; capture = 1'b0; transfer = 1'b0;
    update = 1'b0; io_face = 1'b0; mode = 1'b0; safe = 1'b0; cfi = 4'b0;
    idle = '0;
    idle.cfi = 4'b0011;

    // A reset cycle with shift active has to win.
    s = idle; s.arst = 1'b1; s.shift = 1'b1; s.wsi = 1'b1; s.mode = 1'b1;
    apply_stimulus(s);
    s = idle; s.mode = 1'b1;
    apply_stimulus(s);

    // Stream 1,0,1,1,0,0,1,0 through the chain, then replay it at wso.
    shift_bits(8'b1011_0010, 8, idle);
    shift_bits(8'b0000_0000, 8, idle);

    // Capture the inward face, then unload it.
    s = idle; s.capture = 1'b1; s.cfi = 4'b1010;
    apply_stimulus(s);
    shift_bits(8'b0000_0000, 8, idle);

    // Load s1 with 0110, update, then drive in test mode, in safe mode, and in functional mode.
    shift_bits(8'b0011_1100, 8, idle);
    s = idle; s.update = 1'b1;
    apply_stimulus(s);
    s = idle; s.mode = 1'b1;
    apply_stimulus(s);
    s.safe = 1'b1;
    apply_stimulus(s);
    s.mode = 1'b0; s.cfi = 4'b1110;
    apply_stimulus(s);

    // Priority: shift, capture and transfer together with update, then transfer on its own.
    s = idle; s.shift = 1'b1; s.capture = 1'b1; s.transfer = 1'b1; s.update = 1'b1; s.wsi = 1'b1;
    apply_stimulus(s);
    s = idle; s.transfer = 1'b1;
    apply_stimulus(s);
    s = idle; s.mode = 1'b1; s.io_face = 1'b1; s.capture = 1'b1;
    apply_stimulus(s);
    s = idle; s.mode = 1'b1;
    for (int k = 0; k < 4; k++) apply_stimulus(s);

    for (int k = 0; k < 600; k++) begin
      s.arst     = ($urandom_range(0, 63) == 0);
      s.shift    = ($urandom_range(0, 1) == 1);
      s.capture  = ($urandom_range(0, 3) == 0);
      s.transfer = ($urandom_range(0, 3) == 0);
      s.update   = ($urandom_range(0, 3) == 0);
      s.io_face  = 1'($urandom_range(0, 1));
      s.mode     = 1'($urandom_range(0, 1));
      s.safe     = ($urandom_range(0, 3) == 0);
      s.wsi      = 1'($urandom_range(0, 1));
      s.cfi      = 4'($urandom_range(0, 15));
      apply_stimulus(s);
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
